matrix_result_writer: RTL

//  Downstream stage of Large_Matrix_Mult. Captures each packed result row (Res) when write_ready pulses.

---
 rtl/mmult_pkg.sv | 22 ++
 rtl/mrw_row_fifo.sv | 61 ++++++
 rtl/matrix_result_writer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mmult_pkg.sv
// mmult_pkg: types and helpers shared by Large_Matrix_Mult and its result writer.
//   mrw_state_e    writer FSM states (IDLE, RUN, DRAIN, DONE)
//   MMULT_ROW_T    packed result row type for a given element width and count
//   cnt_width()    width of a counter that must hold the value n
`ifndef MMULT_ROW_T
`define MMULT_ROW_T(W, N) logic [((W)*(N))-1:0]
`endif

package mmult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mrw_state_e;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mrw_row_fifo.sv
// mrw_row_fifo: synchronous row FIFO with registered storage.
//   clk, reset   rising-edge clock, synchronous active-high reset
//   clear        synchronous flush (pointers return to zero)
//   push, din    write din at the tail (ignored when full unless popping)
//   pop          advance the head (ignored when empty)
//   head         row at the head; stable until popped
//   full, empty  occupancy flags
// Pointers carry one extra wrap bit: equal pointers mean empty, pointers
// that differ only in the wrap bit mean full.
module mrw_row_fifo #(
  parameter int WIDTH_BITS = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH_BITS-1:0] din,
  output logic [WIDTH_BITS-1:0] head,
  output logic                  full,
  output logic                  empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [WIDTH_BITS-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic                  do_push_s;
  logic                  do_pop_s;

  // Qualify requests against occupancy; a full FIFO accepts a push only with a same-cycle pop.
  always_comb begin
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
    end
  end

  // Row storage; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r[AW-1:0]] <= din;
  end

  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[PTR_W-1] != rd_ptr_r[PTR_W-1]) &&
                 (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign head  = mem_r[rd_ptr_r[AW-1:0]];

endmodule

// File: rtl/matrix_result_writer.sv
// matrix_result_writer: captures packed result rows from the multiplier,
// buffers them and writes them to result memory, one matrix at a time.
//   clk, reset  rising-edge clock, synchronous active-high reset
//   start       begin a new matrix (honoured in IDLE only)
//   res_data    packed result row; res_valid marks one row per high cycle
//   mem_we      write request, mem_addr/mem_wdata valid; accepted on mem_ready
//   busy        collecting or draining a matrix
//   done        one-cycle pulse after the last row of a matrix is written
//   overflow    sticky: a row was dropped since the last start
//   checksum    (only with MRW_CHECKSUM_EN) per-lane wrapping sum of accepted rows
// Optional feature macro: MRW_CHECKSUM_EN.
module matrix_result_writer
  import mmult_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int NUM_ELEMENTS = 4,
  parameter int MATRIX_WIDTH = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int ADDR_WIDTH   = 8,
  parameter int BASE_ADDR    = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [NUM_ELEMENTS*WIDTH-1:0] res_data,
  input  logic                          res_valid,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [NUM_ELEMENTS*WIDTH-1:0] mem_wdata,
  input  logic                          mem_ready,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow
`ifdef MRW_CHECKSUM_EN
  ,
  output logic [NUM_ELEMENTS*WIDTH-1:0] checksum
`endif
);

  localparam int CNT_W = cnt_width(MATRIX_WIDTH);
  localparam logic [CNT_W-1:0] LAST_IN  = CNT_W'(MATRIX_WIDTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MATRIX_WIDTH);

  mrw_state_e                     state_r;
  mrw_state_e                     state_nxt_s;
  logic [CNT_W-1:0]               in_cnt_r;
  logic [CNT_W-1:0]               out_cnt_r;
  logic                           overflow_r;
  `MMULT_ROW_T(WIDTH, NUM_ELEMENTS) fifo_head_s;
  logic                           fifo_full_s;
  logic                           fifo_empty_s;
  logic                           active_s;
  logic                           start_acc_s;
  logic                           in_step_s;
  logic                           mem_we_s;
  logic                           pop_s;
  logic                           push_s;
  logic                           drop_s;
  logic                           late_s;

  // Handshake qualification; no write is offered while reset is asserted.
  always_comb begin
    active_s    = (state_r == RUN) || (state_r == DRAIN);
    start_acc_s = (state_r == IDLE) && start;
    in_step_s   = (state_r == RUN) && res_valid;
    mem_we_s    = !reset && !fifo_empty_s && active_s;
    pop_s       = mem_we_s && mem_ready;
    push_s      = in_step_s && (!fifo_full_s || pop_s);
    drop_s      = in_step_s && fifo_full_s && !pop_s;
    late_s      = (state_r == DRAIN) && res_valid;
  end

  // Next-state logic. DRAIN also ends once the FIFO is empty so that a
  // matrix with dropped rows (never written) cannot stall the writer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (start) state_nxt_s = RUN; else state_nxt_s = IDLE;
      RUN:     if (res_valid && (in_cnt_r == LAST_IN)) state_nxt_s = DRAIN;
               else state_nxt_s = RUN;
      DRAIN:   if ((out_cnt_r == FULL_CNT) || fifo_empty_s) state_nxt_s = DONE;
               else state_nxt_s = DRAIN;
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nxt_s;
  end

  // Row counters; dropped rows still count as received so the matrix ends on schedule.
  always_ff @(posedge clk) begin
    if (reset || start_acc_s) begin
      in_cnt_r  <= '0;
      out_cnt_r <= '0;
    end else begin
      if (in_step_s) in_cnt_r  <= in_cnt_r + CNT_W'(1);
      if (pop_s)     out_cnt_r <= out_cnt_r + CNT_W'(1);
    end
  end

  // Sticky overflow flag, cleared only by a new matrix or reset.
  always_ff @(posedge clk) begin
    if (reset || start_acc_s)  overflow_r <= 1'b0;
    else if (drop_s || late_s) overflow_r <= 1'b1;
  end

  mrw_row_fifo #(
    .WIDTH_BITS (NUM_ELEMENTS * WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (start_acc_s),
    .push  (push_s),
    .pop   (pop_s),
    .din   (res_data),
    .head  (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

`ifdef MRW_CHECKSUM_EN
  `MMULT_ROW_T(WIDTH, NUM_ELEMENTS) checksum_r;

  function automatic `MMULT_ROW_T(WIDTH, NUM_ELEMENTS) lane_add(
    input `MMULT_ROW_T(WIDTH, NUM_ELEMENTS) a,
    input `MMULT_ROW_T(WIDTH, NUM_ELEMENTS) b
  );
    `MMULT_ROW_T(WIDTH, NUM_ELEMENTS) r;
    r = '0;
    for (int i = 0; i < NUM_ELEMENTS; i++) begin
      r[i*WIDTH +: WIDTH] = a[i*WIDTH +: WIDTH] + b[i*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  // Per-lane running sum of every row accepted into the FIFO.
  always_ff @(posedge clk) begin
    if (reset || start_acc_s) checksum_r <= '0;
    else if (push_s)          checksum_r <= lane_add(checksum_r, res_data);
  end

  assign checksum = checksum_r;
`endif

  assign mem_we    = mem_we_s;
  assign mem_addr  = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(out_cnt_r);
  assign mem_wdata = fifo_head_s;
  assign busy      = active_s;
  assign done      = (state_r == DONE);
  assign overflow  = overflow_r;

endmodule
